router_input_arbiter: RTL and testbench

Round-robin arbiter that merges ninputs val/rdy request streams into the single input stream of a Router. One message is granted per accepted cycle. The granted message is captured in a one-entry output register, so the Router input sees a registered, back-pressure-safe stream. The block sits directly upstream of the Router's istream port.

---
 rtl/router_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/router_input_arbiter.sv | 87 ++++++++
 tb/tb_router_input_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants and helpers.
// Keeps arbiter and Router message widths tied to one definition.
package router_pkg;

    // Default message width shared by the Router and its input arbiter.
    localparam int NBITS_DEFAULT = 32;

    // Select/index width for n requesters; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (requests), ptr (highest-priority index), en (grant enable),
//        gnt (one-hot grant, gated by en), gnt_idx (winner), next_ptr.
import router_pkg::*;

module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = sel_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic [SW-1:0] next_ptr
);

    logic found;
    int   j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        // Scan from ptr upward, wrapping modulo N without relying on
        // power-of-two overflow.
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt_idx = SW'(j);
                gnt[j]  = en;
            end
        end
        if (!found) begin
            next_ptr = ptr;
        end else if (gnt_idx == SW'(N - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = gnt_idx + SW'(1);
        end
    end

endmodule

// File: rtl/router_input_arbiter.sv
// Round-robin merge of ninputs val/rdy streams into one registered stream.
// Ports: clk, reset (async high), istream_val/msg/rdy (per requester),
//        ostream_val/msg/rdy (merged output), grant_idx (trace of held entry).
import router_pkg::*;

module router_input_arbiter #(
    parameter int nbits   = NBITS_DEFAULT,
    parameter int ninputs = 4,
    localparam int SW     = sel_w(ninputs)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ninputs-1:0]              istream_val,
    input  logic [ninputs-1:0][nbits-1:0]   istream_msg,
    output logic [ninputs-1:0]              istream_rdy,
    output logic                            ostream_val,
    output logic [nbits-1:0]                ostream_msg,
    input  logic                            ostream_rdy,
    output logic [SW-1:0]                   grant_idx
);

    logic             full_q, full_d;
    logic [nbits-1:0] msg_q, msg_d;
    logic [SW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    logic             drain;
    logic             can_accept;
    logic             accept;
    logic [ninputs-1:0] gnt;
    logic [SW-1:0]    win_idx;
    logic [SW-1:0]    win_next;

    assign drain      = full_q & ostream_rdy;
    // Drain and refill in the same cycle keeps full throughput.
    assign can_accept = (!full_q | drain) & !reset;

    rr_arbiter #(
        .N  (ninputs),
        .SW (SW)
    ) u_rr (
        .req      (istream_val),
        .ptr      (ptr_q),
        .en       (can_accept),
        .gnt      (gnt),
        .gnt_idx  (win_idx),
        .next_ptr (win_next)
    );

    // gnt is only set on a valid requester, so any grant is an accept.
    assign istream_rdy = gnt;
    assign accept      = |gnt;

    always_comb begin
        full_d = full_q;
        msg_d  = msg_q;
        idx_d  = idx_q;
        ptr_d  = ptr_q;
        if (accept) begin
            full_d = 1'b1;
            msg_d  = istream_msg[win_idx];
            idx_d  = win_idx;
            ptr_d  = win_next;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            msg_q  <= '0;
            idx_q  <= '0;
            ptr_q  <= '0;
        end else begin
            full_q <= full_d;
            msg_q  <= msg_d;
            idx_q  <= idx_d;
            ptr_q  <= ptr_d;
        end
    end

    assign ostream_val = full_q;
    assign ostream_msg = msg_q;
    assign grant_idx   = idx_q;

endmodule

// File: tb/tb_router_input_arbiter.sv
// Directed self-checking bench for router_input_arbiter.
// Four 32-bit requesters; hand-computed expectations per scenario.
module tb_router_input_arbiter;

    logic             clk;
    logic             reset;
    logic [3:0]       istream_val;
    logic [3:0][31:0] istream_msg;
    logic [3:0]       istream_rdy;
    logic             ostream_val;
    logic [31:0]      ostream_msg;
    logic             ostream_rdy;
    logic [1:0]       grant_idx;

    int n_checks = 0;
    int n_fail   = 0;

    router_input_arbiter #(
        .nbits   (32),
        .ninputs (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_msg (istream_msg),
        .istream_rdy (istream_rdy),
        .ostream_val (ostream_val),
        .ostream_msg (ostream_msg),
        .ostream_rdy (ostream_rdy),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_msgs(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            istream_msg[i] = base + 32'(i);
        end
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        istream_val = 4'b1111;
        ostream_rdy = 1'b1;
        set_msgs(32'h10);
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (istream_rdy !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_rdy cyc%0d: got %b want 0000", c, istream_rdy);
            end
            n_checks++;
            if (ostream_val !== 1'b0 || grant_idx !== 2'd0 || ostream_msg !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_out cyc%0d: val=%b idx=%0d msg=%h want 0/0/0",
                         c, ostream_val, grant_idx, ostream_msg);
            end
        end
        istream_val = 4'b0000;
        #3;
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if (ostream_val !== 1'b0 || istream_rdy !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_after_reset: val=%b rdy=%b want 0/0000",
                     ostream_val, istream_rdy);
        end
    endtask

    task automatic test_contention;
        set_msgs(32'h10);
        istream_val = 4'b1111;
        ostream_rdy = 1'b1;
        #1;
        n_checks++;
        if (istream_rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL cont_first_rdy: got %b want 0001", istream_rdy);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if (ostream_val !== 1'b1 || ostream_msg !== 32'h10 + 32'(k % 4)
                || grant_idx !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL cont_seq%0d: val=%b msg=%h idx=%0d want 1/%h/%0d",
                         k, ostream_val, ostream_msg, grant_idx,
                         32'h10 + 32'(k % 4), k % 4);
            end
        end
        istream_val = 4'b0000;
        step();
        n_checks++;
        if (ostream_val !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_drain: val=%b want 0", ostream_val);
        end
    endtask

    task automatic test_single;
        istream_val = 4'b0100;
        istream_msg[2] = 32'hA000_0002;
        ostream_rdy = 1'b1;
        #1;
        n_checks++;
        if (istream_rdy !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_rdy: got %b want 0100", istream_rdy);
        end
        step();
        n_checks++;
        if (ostream_val !== 1'b1 || ostream_msg !== 32'hA000_0002 || grant_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL single_out: val=%b msg=%h idx=%0d want 1/a0000002/2",
                     ostream_val, ostream_msg, grant_idx);
        end
        // Pointer now 3: with 0 and 3 requesting, 3 must win.
        istream_val = 4'b1001;
        #1;
        n_checks++;
        if (istream_rdy !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_nextprio: got %b want 1000", istream_rdy);
        end
        istream_val = 4'b0000;
        step();
        n_checks++;
        if (ostream_val !== 1'b0 || ostream_msg !== 32'hA000_0002) begin
            n_fail++;
            $display("FAIL single_drain: val=%b msg=%h want 0/a0000002",
                     ostream_val, ostream_msg);
        end
    endtask

    task automatic test_wraparound;
        set_msgs(32'h30);
        istream_val = 4'b1001;
        ostream_rdy = 1'b1;
        step();
        n_checks++;
        if (ostream_msg !== 32'h33 || grant_idx !== 2'd3 || ostream_val !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_first: msg=%h idx=%0d val=%b want 33/3/1",
                     ostream_msg, grant_idx, ostream_val);
        end
        step();
        n_checks++;
        if (ostream_msg !== 32'h30 || grant_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_second: msg=%h idx=%0d want 30/0",
                     ostream_msg, grant_idx);
        end
        // Pointer back at 1: search 1,2,3 finds 3 first.
        n_checks++;
        if (istream_rdy !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_ptr: rdy=%b want 1000", istream_rdy);
        end
        istream_val = 4'b0000;
        step();
    endtask

    task automatic test_backpressure;
        // Pointer is 1; load 0x11 from input 1, pointer becomes 2.
        set_msgs(32'h10);
        istream_val = 4'b0010;
        ostream_rdy = 1'b1;
        step();
        istream_val = 4'b1001;
        ostream_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (istream_rdy !== 4'b0000 || ostream_val !== 1'b1
                || ostream_msg !== 32'h11 || grant_idx !== 2'd1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: rdy=%b val=%b msg=%h idx=%0d want 0000/1/11/1",
                         c, istream_rdy, ostream_val, ostream_msg, grant_idx);
            end
            step();
        end
        ostream_rdy = 1'b1;
        #1;
        n_checks++;
        if (istream_rdy !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_release_rdy: got %b want 1000", istream_rdy);
        end
        step();
        n_checks++;
        if (ostream_msg !== 32'h13 || grant_idx !== 2'd3 || ostream_val !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_out: msg=%h idx=%0d val=%b want 13/3/1",
                     ostream_msg, grant_idx, ostream_val);
        end
        istream_val = 4'b0000;
        step();
        n_checks++;
        if (ostream_val !== 1'b0 || ostream_msg !== 32'h13) begin
            n_fail++;
            $display("FAIL bp_drain: val=%b msg=%h want 0/13", ostream_val, ostream_msg);
        end
    endtask

    task automatic test_async_reset;
        // Pointer 0: grants 0 then 1, pointer left at 2.
        set_msgs(32'h10);
        istream_val = 4'b1111;
        ostream_rdy = 1'b1;
        step();
        step();
        ostream_rdy = 1'b0;
        #1;
        n_checks++;
        if (ostream_val !== 1'b1 || ostream_msg !== 32'h11) begin
            n_fail++;
            $display("FAIL ar_pre: val=%b msg=%h want 1/11", ostream_val, ostream_msg);
        end
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ostream_val !== 1'b0 || ostream_msg !== 32'h0 || grant_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL ar_drop: val=%b msg=%h idx=%0d want 0/0/0",
                     ostream_val, ostream_msg, grant_idx);
        end
        #2;
        reset = 1'b0;
        ostream_rdy = 1'b1;
        #1;
        n_checks++;
        if (istream_rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL ar_ptr_rdy: got %b want 0001", istream_rdy);
        end
        step();
        n_checks++;
        if (ostream_val !== 1'b1 || ostream_msg !== 32'h10 || grant_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL ar_first_grant: val=%b msg=%h idx=%0d want 1/10/0",
                     ostream_val, ostream_msg, grant_idx);
        end
        istream_val = 4'b0000;
        step();
    endtask

    initial begin
        reset       = 1'b1;
        istream_val = 4'b0000;
        istream_msg = '0;
        ostream_rdy = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_wraparound();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
